// File: rtl/surfturf_wb_splitter.sv
`default_nettype none
// ============================================================================
// Module : surfturf_wb_splitter
// Desc   : Classic-Wishbone splitter to N_CH channel ports plus one aux port,
//          one transaction in flight. Optional slave-ack timeout is built when
//          SURFTURF_WB_TIMEOUT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module surfturf_wb_splitter #(
  parameter int ADDR_WIDTH     = 12,
  parameter int N_CH           = 8,
  parameter int CH_ADDR_BITS   = 6,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SEL_BITS       = ADDR_WIDTH - 1 - CH_ADDR_BITS
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rstn_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
  input  logic [3:0]                   wb_sel_i,
  input  logic [31:0]                  wb_dat_i,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  output logic                         wb_rty_o,
  output logic [31:0]                  wb_dat_o,
  output logic [N_CH-1:0]              ch_cyc_o,
  output logic [N_CH-1:0]              ch_stb_o,
  output logic [N_CH-1:0]              ch_we_o,
  output logic [N_CH*CH_ADDR_BITS-1:0] ch_adr_o,
  output logic [N_CH*4-1:0]            ch_sel_o,
  output logic [N_CH*32-1:0]           ch_dat_o,
  input  logic [N_CH-1:0]              ch_ack_i,
  input  logic [N_CH-1:0]              ch_err_i,
  input  logic [N_CH*32-1:0]           ch_dat_i,
  output logic                         aux_cyc_o,
  output logic                         aux_stb_o,
  output logic                         aux_we_o,
  output logic [ADDR_WIDTH-2:0]        aux_adr_o,
  output logic [3:0]                   aux_sel_o,
  output logic [31:0]                  aux_dat_o,
  input  logic                         aux_ack_i,
  input  logic                         aux_err_i,
  input  logic [31:0]                  aux_dat_i,
  output logic                         timeout_o,
  output logic [5:0]                   timeout_ch_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  logic [1:0]            r_sync;
  logic                  r_stb;
  logic                  r_aux;
  logic [N_CH-1:0]       r_ch_sel;
  logic [ADDR_WIDTH-2:0] r_adr;
  logic                  r_we;
  logic [3:0]            r_sel;
  logic [31:0]           r_dat;
  logic                  r_ack;
  logic                  r_err;
  logic [31:0]           r_dat_o;

  logic                  w_aux;
  logic [SEL_BITS-1:0]   w_idx;
  logic [N_CH-1:0]       w_onehot;
  logic                  w_mapped;
  logic                  w_sack;
  logic                  w_serr;
  logic [31:0]           w_sdat;

`ifdef SURFTURF_WB_TIMEOUT_EN
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt;
  logic [5:0]  r_idx;
  logic        r_timeout;
  logic [5:0]  r_timeout_ch;
`endif

  assign w_aux    = wb_adr_i[ADDR_WIDTH-1];
  assign w_idx    = wb_adr_i[CH_ADDR_BITS +: SEL_BITS];
  assign w_mapped = w_aux | (|w_onehot);

  // r_ch_sel is one-hot (or zero), so OR-reduction acts as the response mux
  always_comb begin
    w_onehot = '0;
    w_sack   = r_aux & aux_ack_i;
    w_serr   = r_aux & aux_err_i;
    w_sdat   = r_aux ? aux_dat_i : 32'h0;
    for (int i = 0; i < N_CH; i++) begin
      w_onehot[i] = (int'(w_idx) == i);
      if (r_ch_sel[i]) begin
        w_sack = w_sack | ch_ack_i[i];
        w_serr = w_serr | ch_err_i[i];
        w_sdat = w_sdat | ch_dat_i[i*32 +: 32];
      end
    end
  end

  // Reset release is synchronised; r_sync[1] gates transaction acceptance
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_state  <= S_IDLE;
      r_stb    <= 1'b0;
      r_aux    <= 1'b0;
      r_ch_sel <= '0;
      r_adr    <= '0;
      r_we     <= 1'b0;
      r_sel    <= 4'h0;
      r_dat    <= 32'h0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat_o  <= 32'h0;
`ifdef SURFTURF_WB_TIMEOUT_EN
      r_cnt        <= 16'h0;
      r_idx        <= 6'h00;
      r_timeout    <= 1'b0;
      r_timeout_ch <= 6'h00;
`endif
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
`ifdef SURFTURF_WB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (r_sync[1] && wb_cyc_i && wb_stb_i) begin
            r_adr    <= wb_adr_i[ADDR_WIDTH-2:0];
            r_we     <= wb_we_i;
            r_sel    <= wb_sel_i;
            r_dat    <= wb_dat_i;
            r_aux    <= w_aux;
            r_ch_sel <= w_aux ? '0 : w_onehot;
`ifdef SURFTURF_WB_TIMEOUT_EN
            r_idx    <= w_aux ? 6'h3F : 6'(w_idx);
            r_cnt    <= 16'h0;
`endif
            if (w_mapped) begin
              r_stb   <= 1'b1;
              r_state <= S_ACTIVE;
            end else begin
              r_err   <= 1'b1;
              r_dat_o <= 32'h0;
              r_state <= S_RESP;
            end
          end
        end
        S_ACTIVE: begin
          if (!wb_cyc_i) begin
            r_stb   <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_sack || w_serr) begin
            r_stb   <= 1'b0;
            r_dat_o <= w_sdat;
            r_ack   <= ~w_serr;
            r_err   <= w_serr;
            r_state <= S_RESP;
          end
`ifdef SURFTURF_WB_TIMEOUT_EN
          else if (r_cnt == c_TO_LAST) begin
            r_stb        <= 1'b0;
            r_dat_o      <= 32'h0;
            r_err        <= 1'b1;
            r_timeout    <= 1'b1;
            r_timeout_ch <= r_idx;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // An upstream abort during the response cycle suppresses ack/err
  assign wb_ack_o = r_ack & wb_cyc_i;
  assign wb_err_o = r_err & wb_cyc_i;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = r_dat_o;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign ch_cyc_o[g]                            = r_stb & r_ch_sel[g];
    assign ch_stb_o[g]                            = r_stb & r_ch_sel[g];
    assign ch_we_o[g]                             = r_we & r_ch_sel[g];
    assign ch_adr_o[g*CH_ADDR_BITS +: CH_ADDR_BITS] = r_adr[CH_ADDR_BITS-1:0];
    assign ch_sel_o[g*4 +: 4]                     = r_sel;
    assign ch_dat_o[g*32 +: 32]                   = r_dat;
  end

  assign aux_cyc_o = r_stb & r_aux;
  assign aux_stb_o = r_stb & r_aux;
  assign aux_we_o  = r_we & r_aux;
  assign aux_adr_o = r_adr;
  assign aux_sel_o = r_sel;
  assign aux_dat_o = r_dat;

`ifdef SURFTURF_WB_TIMEOUT_EN
  assign timeout_o    = r_timeout;
  assign timeout_ch_o = r_timeout_ch;
`else
  assign timeout_o    = 1'b0;
  assign timeout_ch_o = 6'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_surfturf_wb_splitter.sv
`default_nettype none
// ============================================================================
// Module : tb_surfturf_wb_splitter
// Desc   : Directed self-checking bench for surfturf_wb_splitter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_surfturf_wb_splitter;

  localparam int AW = 12;
  localparam int NC = 8;
  localparam int CB = 6;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic            cyc, stb, we;
  logic [AW-1:0]   adr;
  logic [3:0]      sel;
  logic [31:0]     dat_w;
  logic            wb_ack, wb_err, wb_rty;
  logic [31:0]     wb_dat;
  logic [NC-1:0]   ch_cyc, ch_stb, ch_we;
  logic [NC*CB-1:0] ch_adr;
  logic [NC*4-1:0] ch_sel;
  logic [NC*32-1:0] ch_dat_out;
  logic [NC-1:0]   ch_ack, ch_err;
  logic [NC*32-1:0] ch_dat_in;
  logic            aux_cyc, aux_stb, aux_we;
  logic [AW-2:0]   aux_adr;
  logic [3:0]      aux_sel;
  logic [31:0]     aux_dat_out;
  logic            aux_ack, aux_err;
  logic [31:0]     aux_dat_in;
  logic            timeout;
  logic [5:0]      timeout_ch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  surfturf_wb_splitter #(
    .ADDR_WIDTH(AW), .N_CH(NC), .CH_ADDR_BITS(CB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_dat_i(dat_w),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_rty_o(wb_rty), .wb_dat_o(wb_dat),
    .ch_cyc_o(ch_cyc), .ch_stb_o(ch_stb), .ch_we_o(ch_we), .ch_adr_o(ch_adr),
    .ch_sel_o(ch_sel), .ch_dat_o(ch_dat_out),
    .ch_ack_i(ch_ack), .ch_err_i(ch_err), .ch_dat_i(ch_dat_in),
    .aux_cyc_o(aux_cyc), .aux_stb_o(aux_stb), .aux_we_o(aux_we), .aux_adr_o(aux_adr),
    .aux_sel_o(aux_sel), .aux_dat_o(aux_dat_out),
    .aux_ack_i(aux_ack), .aux_err_i(aux_err), .aux_dat_i(aux_dat_in),
    .timeout_o(timeout), .timeout_ch_o(timeout_ch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    ch_ack = '0; ch_err = '0; aux_ack = 1'b0; aux_err = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] a, input logic w, input logic [31:0] d);
    adr = a; we = w; dat_w = d; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_bus();
    adr = '0; sel = 4'h0; dat_w = '0; ch_dat_in = '0; aux_dat_in = '0;
    tick(); tick();
    checks++; if (wb_ack !== 1'b0 || wb_err !== 1'b0 || wb_rty !== 1'b0) begin errors++; $display("FAIL reset_resp: ack/err/rty=%b%b%b expected 000", wb_ack, wb_err, wb_rty); end
    checks++; if (ch_stb !== 8'h00 || ch_cyc !== 8'h00 || aux_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: ch_stb=%h aux_stb=%b expected 00/0", ch_stb, aux_stb); end
    checks++; if (wb_dat !== 32'h0 || timeout !== 1'b0 || timeout_ch !== 6'h00) begin errors++; $display("FAIL reset_regs: dat=%h to=%b to_ch=%h expected 0", wb_dat, timeout, timeout_ch); end
    @(negedge clk); rstn = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_ch_read();
    start(12'h0C4, 1'b0, 32'h0);
    tick();
    checks++; if (ch_stb !== 8'h08 || aux_stb !== 1'b0) begin errors++; $display("FAIL ch3_stb: ch_stb=%h aux=%b expected 08/0", ch_stb, aux_stb); end
    checks++; if (ch_adr[3*CB +: CB] !== 6'h04) begin errors++; $display("FAIL ch3_adr: got %h expected 04", ch_adr[3*CB +: CB]); end
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL ch3_early_ack: got %b expected 0", wb_ack); end
    ch_ack[3] = 1'b1; ch_dat_in[3*32 +: 32] = 32'hCAFE0001;
    tick();
    checks++; if (wb_ack !== 1'b1 || wb_err !== 1'b0) begin errors++; $display("FAIL ch3_ack: ack/err=%b%b expected 10", wb_ack, wb_err); end
    checks++; if (wb_dat !== 32'hCAFE0001) begin errors++; $display("FAIL ch3_dat: got %h expected cafe0001", wb_dat); end
    checks++; if (ch_stb !== 8'h00) begin errors++; $display("FAIL ch3_stb_drop: got %h expected 00", ch_stb); end
    idle_bus();
    tick();
    checks++; if (wb_ack !== 1'b0 || wb_dat !== 32'hCAFE0001) begin errors++; $display("FAIL ch3_hold: ack=%b dat=%h expected 0/cafe0001", wb_ack, wb_dat); end
  endtask

  task automatic test_aux_write();
    aux_dat_in = 32'hA5A50000;
    start(12'h804, 1'b1, 32'h12345678);
    tick();
    checks++; if (aux_stb !== 1'b1 || aux_we !== 1'b1 || ch_stb !== 8'h00) begin errors++; $display("FAIL aux_stb: stb=%b we=%b ch=%h expected 1/1/00", aux_stb, aux_we, ch_stb); end
    checks++; if (aux_adr !== 11'h004 || aux_dat_out !== 32'h12345678) begin errors++; $display("FAIL aux_adr_dat: adr=%h dat=%h expected 004/12345678", aux_adr, aux_dat_out); end
    tick();
    checks++; if (wb_ack !== 1'b0 || aux_stb !== 1'b1) begin errors++; $display("FAIL aux_wait: ack=%b stb=%b expected 0/1", wb_ack, aux_stb); end
    tick();
    aux_ack = 1'b1;
    tick();
    checks++; if (wb_ack !== 1'b1 || wb_dat !== 32'hA5A50000) begin errors++; $display("FAIL aux_ack: ack=%b dat=%h expected 1/a5a50000", wb_ack, wb_dat); end
    idle_bus();
    tick();
  endtask

  task automatic test_unmapped();
    start(12'h600, 1'b0, 32'h0);
    tick();
    checks++; if (wb_err !== 1'b1 || wb_ack !== 1'b0) begin errors++; $display("FAIL unmap_err: ack/err=%b%b expected 01", wb_ack, wb_err); end
    checks++; if (wb_dat !== 32'h0 || ch_stb !== 8'h00 || aux_stb !== 1'b0) begin errors++; $display("FAIL unmap_side: dat=%h ch=%h aux=%b expected 0", wb_dat, ch_stb, aux_stb); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL unmap_to: got %b expected 0", timeout); end
    idle_bus();
    tick();
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL unmap_err_len: got %b expected 0", wb_err); end
  endtask

  task automatic test_ack_err();
    start(12'h008, 1'b0, 32'h0);
    tick();
    ch_ack[0] = 1'b1; ch_err[0] = 1'b1; ch_dat_in[0 +: 32] = 32'hDEADBEEF;
    tick();
    checks++; if (wb_err !== 1'b1 || wb_ack !== 1'b0) begin errors++; $display("FAIL ackerr: ack/err=%b%b expected 01", wb_ack, wb_err); end
    checks++; if (wb_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL ackerr_dat: got %h expected deadbeef", wb_dat); end
    idle_bus();
    tick();
  endtask

  task automatic test_abort();
    start(12'h080, 1'b0, 32'h0);
    tick();
    checks++; if (ch_stb !== 8'h04) begin errors++; $display("FAIL abort_stb: got %h expected 04", ch_stb); end
    tick();
    cyc = 1'b0; stb = 1'b0;
    tick();
    checks++; if (ch_stb !== 8'h00) begin errors++; $display("FAIL abort_drop: got %h expected 00", ch_stb); end
    ch_ack[2] = 1'b1; ch_dat_in[2*32 +: 32] = 32'hBAD00002;
    start(12'h040, 1'b0, 32'h0);
    tick();
    checks++; if (wb_ack !== 1'b0 || wb_err !== 1'b0 || ch_stb !== 8'h02) begin errors++; $display("FAIL abort_late: ack/err=%b%b ch=%h expected 00/02", wb_ack, wb_err, ch_stb); end
    ch_ack[2] = 1'b0; ch_ack[1] = 1'b1; ch_dat_in[1*32 +: 32] = 32'h11112222;
    tick();
    checks++; if (wb_ack !== 1'b1 || wb_dat !== 32'h11112222) begin errors++; $display("FAIL abort_next: ack=%b dat=%h expected 1/11112222", wb_ack, wb_dat); end
    idle_bus();
    tick();
  endtask

  task automatic test_timeout();
    int  n;
    bit  seen;
    n = 0; seen = 1'b0;
    start(12'h140, 1'b0, 32'h0);
`ifdef SURFTURF_WB_TIMEOUT_EN
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(); n++;
      if (wb_err) seen = 1'b1;
    end
    checks++; if (!seen || n < TO || n > TO + 2) begin errors++; $display("FAIL to_err: seen=%b after %0d cycles expected 1 near %0d", seen, n, TO + 1); end
    checks++; if (timeout !== 1'b1 || timeout_ch !== 6'd5) begin errors++; $display("FAIL to_pulse: to=%b ch=%h expected 1/05", timeout, timeout_ch); end
    checks++; if (wb_dat !== 32'h0 || wb_ack !== 1'b0 || ch_stb !== 8'h00) begin errors++; $display("FAIL to_side: dat=%h ack=%b ch=%h expected 0", wb_dat, wb_ack, ch_stb); end
    idle_bus();
    tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_len: got %b expected 0", timeout); end
    cyc = 1'b1; ch_ack[5] = 1'b1;
    tick(); tick();
    checks++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin errors++; $display("FAIL to_late_ack: ack/err=%b%b expected 00", wb_ack, wb_err); end
`else
    for (int i = 0; i < 40; i++) begin
      tick(); n++;
      if (wb_err || wb_ack || timeout || ch_stb !== 8'h20) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL no_to_wait: activity=%b after %0d cycles expected 0", seen, n); end
    cyc = 1'b0; stb = 1'b0;
    tick();
    checks++; if (ch_stb !== 8'h00 || timeout_ch !== 6'h00) begin errors++; $display("FAIL no_to_abort: ch=%h to_ch=%h expected 00/00", ch_stb, timeout_ch); end
`endif
    idle_bus();
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    start(12'h100, 1'b0, 32'h0);
    tick();
    checks++; if (ch_stb !== 8'h10) begin errors++; $display("FAIL rst_pre: got %h expected 10", ch_stb); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (ch_stb !== 8'h00 || ch_cyc !== 8'h00 || wb_dat !== 32'h0) begin errors++; $display("FAIL rst_async: ch=%h dat=%h expected 00/0", ch_stb, wb_dat); end
    idle_bus();
    ch_ack[4] = 1'b1;
    tick(); tick();
    checks++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin errors++; $display("FAIL rst_held: ack/err=%b%b expected 00", wb_ack, wb_err); end
    @(negedge clk); rstn = 1'b1;
    ch_ack = '0;
    start(12'h000, 1'b0, 32'h0);
    tick();
    checks++; if (ch_stb !== 8'h00 || wb_ack !== 1'b0) begin errors++; $display("FAIL rst_sync: ch=%h ack=%b expected 00/0", ch_stb, wb_ack); end
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (ch_stb[0]) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_accept: ch0 stb=%b expected 1", seen); end
    ch_ack[0] = 1'b1; ch_dat_in[0 +: 32] = 32'h600D0000;
    tick();
    checks++; if (wb_ack !== 1'b1 || wb_dat !== 32'h600D0000) begin errors++; $display("FAIL rst_after: ack=%b dat=%h expected 1/600d0000", wb_ack, wb_dat); end
    idle_bus();
    tick();
  endtask

  initial begin
    test_reset();
    test_ch_read();
    test_aux_write();
    test_unmapped();
    test_ack_err();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
